operand_fetch: RTL and testbench

Decode and operand-fetch stage sitting directly upstream of the ALU execute stage. It accepts 16-bit instructions over a valid/ready handshake, decodes the opcode and register fields, and reads both operands from an internal 8 x 16 register file. It presents a registered operation/src/dst bundle to execute and accepts writebacks from the stage after execute. A per-register busy scoreboard, with same-cycle writeback bypass, stalls instructions whose operands are still in flight.

---
 rtl/proc_pkg.sv | 35 +++
 rtl/reg_file.sv | 37 +++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the decode/execute/writeback stages.
// Holds the opcode encodings, the instruction field bit positions,
// the default register-file geometry, and small opcode-classification
// helpers that report which operands an opcode reads.
package proc_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_NOP = 3'b010;

  // Instruction layout: [15:13] opcode, [12:10] dst, [9:7] src, [6:0] unused
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int DST_MSB = 12;
  localparam int DST_LSB = 10;
  localparam int SRC_MSB = 9;
  localparam int SRC_LSB = 7;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_NOT) || (op == OP_NOP);
  endfunction

  function automatic logic op_reads_src(input logic [2:0] op);
    return (op == OP_ADD);
  endfunction

  // Every opcode that reads dst also writes it back.
  function automatic logic op_uses_dst(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: NUM_REGS x DATA_W storage with two combinational read
// ports and one synchronous write port. Synchronous active-high reset
// clears every entry to zero.
// Ports:
//   clk, rst          clock and synchronous reset
//   we_i/waddr_i/wdata_i  write port
//   raddr_a_i/rdata_a_o   read port A (combinational)
//   raddr_b_i/rdata_b_o   read port B (combinational)
module reg_file #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a_i,
  output logic [DATA_W-1:0]           rdata_a_o,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b_i,
  output logic [DATA_W-1:0]           rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/operand_fetch.sv
// Decode and operand-fetch stage feeding the ALU execute stage.
// Accepts instructions over a valid/ready handshake, reads operands from
// the register file (with same-cycle writeback bypass), tracks in-flight
// destinations in a busy scoreboard and stalls on hazards. The execute
// bundle is registered and held while execute back-pressures.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   instr_valid/instr_ready/instr    upstream instruction handshake
//   wb_en/wb_addr/wb_data            writeback from the stage after execute
//   ex_valid/ex_ready                execute handshake
//   ex_operation/ex_src/ex_dst/ex_dst_addr/ex_illegal  execute bundle
//   stall_count                      cycles with instr_valid && !instr_ready
module operand_fetch #(
  parameter int NUM_REGS = proc_pkg::NUM_REGS,
  parameter int DATA_W   = proc_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [DATA_W-1:0]           instr,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [2:0]                  ex_operation,
  output logic [DATA_W-1:0]           ex_src,
  output logic [DATA_W-1:0]           ex_dst,
  output logic [$clog2(NUM_REGS)-1:0] ex_dst_addr,
  output logic                        ex_illegal,
  output logic [15:0]                 stall_count
);
  import proc_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [2:0]          opc;
  logic [AW-1:0]       dst_a, src_a;
  logic                rd_src, use_dst, legal;
  logic                src_wb_hit, dst_wb_hit, hazard, accept;
  logic [DATA_W-1:0]   rf_src, rf_dst, src_val, dst_val;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [15:0]         stall_q;
  logic                ex_valid_q, ex_illegal_q;
  logic [2:0]          ex_op_q;
  logic [DATA_W-1:0]   ex_src_q, ex_dst_q;
  logic [AW-1:0]       ex_dst_addr_q;

  assign opc     = instr[OPC_MSB:OPC_LSB];
  assign dst_a   = instr[DST_MSB:DST_LSB];
  assign src_a   = instr[SRC_MSB:SRC_LSB];
  assign legal   = op_legal(opc);
  assign rd_src  = op_reads_src(opc);
  assign use_dst = op_uses_dst(opc);

  reg_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (src_a),
    .rdata_a_o (rf_src),
    .raddr_b_i (dst_a),
    .rdata_b_o (rf_dst)
  );

  // A writeback landing this cycle both bypasses the operand and resolves
  // the hazard on that register.
  assign src_wb_hit = wb_en && (wb_addr == src_a);
  assign dst_wb_hit = wb_en && (wb_addr == dst_a);

  assign hazard = (rd_src  && busy_q[src_a] && !src_wb_hit) ||
                  (use_dst && busy_q[dst_a] && !dst_wb_hit);

  assign instr_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  assign src_val = !rd_src  ? '0 : (src_wb_hit ? wb_data : rf_src);
  assign dst_val = !use_dst ? '0 : (dst_wb_hit ? wb_data : rf_dst);

  // Clear before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (accept && use_dst) busy_d[dst_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      stall_q       <= '0;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_src_q      <= '0;
      ex_dst_q      <= '0;
      ex_dst_addr_q <= '0;
      ex_illegal_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (instr_valid && !instr_ready) stall_q <= stall_q + 16'd1;
      if (accept) begin
        ex_valid_q    <= 1'b1;
        ex_op_q       <= legal ? opc : OP_NOP;
        ex_src_q      <= src_val;
        ex_dst_q      <= dst_val;
        ex_dst_addr_q <= use_dst ? dst_a : '0;
        ex_illegal_q  <= !legal;
      end else if (ex_valid_q && ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_operation = ex_op_q;
  assign ex_src       = ex_src_q;
  assign ex_dst       = ex_dst_q;
  assign ex_dst_addr  = ex_dst_addr_q;
  assign ex_illegal   = ex_illegal_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_operation;
  logic [15:0] ex_src;
  logic [15:0] ex_dst;
  logic [2:0]  ex_dst_addr;
  logic        ex_illegal;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_operation (ex_operation),
    .ex_src       (ex_src),
    .ex_dst       (ex_dst),
    .ex_dst_addr  (ex_dst_addr),
    .ex_illegal   (ex_illegal),
    .stall_count  (stall_count)
  );

  // Reference model state: architectural registers, in-flight flags,
  // the pending execute bundle and the stall counter.
  logic [15:0] m_rf   [8];
  bit          m_busy [8];
  bit          m_exv, m_ill;
  logic [2:0]  m_op, m_da;
  logic [15:0] m_src, m_dst, m_cnt;
  bit          last_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s);
    return {op, d, s, 7'h00};
  endfunction

  // One clock cycle: drive inputs, check instr_ready, advance the model,
  // then check the registered outputs after the edge.
  task automatic step(input bit r, input bit v, input logic [15:0] ins,
                      input bit we, input logic [2:0] wa, input logic [15:0] wd,
                      input bit er);
    logic [2:0]  op, d, s;
    bit          rs, rd, hz, rdy, acc;
    logic [15:0] sv, dv;
    @(negedge clk);
    rst = r; instr_valid = v; instr = ins;
    wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
    #1;
    op = ins[15:13]; d = ins[12:10]; s = ins[9:7];
    rs = (op == 3'd0);
    rd = (op == 3'd0) || (op == 3'd1);
    hz = (rs && m_busy[s] && !(we && wa == s)) ||
         (rd && m_busy[d] && !(we && wa == d));
    rdy = (!m_exv || er) && !hz;
    last_rdy = rdy;
    if (!r) chk("instr_ready", instr_ready, rdy);
    if (r) begin
      foreach (m_rf[i]) begin m_rf[i] = 0; m_busy[i] = 0; end
      m_exv = 0; m_ill = 0; m_op = 0; m_da = 0; m_src = 0; m_dst = 0; m_cnt = 0;
    end else begin
      acc = v && rdy;
      sv = rs ? ((we && wa == s) ? wd : m_rf[s]) : 16'h0;
      dv = rd ? ((we && wa == d) ? wd : m_rf[d]) : 16'h0;
      if (v && !rdy) m_cnt = m_cnt + 16'd1;
      if (we) begin m_busy[wa] = 0; m_rf[wa] = wd; end
      if (acc) begin
        if (rd) m_busy[d] = 1;
        m_exv = 1;
        m_op  = (op <= 3'd2) ? op : 3'd2;
        m_ill = (op > 3'd2);
        m_src = sv; m_dst = dv;
        m_da  = rd ? d : 3'd0;
      end else if (m_exv && er) begin
        m_exv = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, m_exv);
    chk("stall_count", stall_count, m_cnt);
    if (m_exv) begin
      chk("ex_operation", ex_operation, m_op);
      chk("ex_src", ex_src, m_src);
      chk("ex_dst", ex_dst, m_dst);
      chk("ex_illegal", ex_illegal, m_ill);
      if (!m_ill && m_op != 3'd2) chk("ex_dst_addr", ex_dst_addr, m_da);
    end
  endtask

  initial begin
    rst = 1; instr_valid = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    step(1, 0, 16'h0, 0, 0, 0, 1);
    step(1, 0, 16'h0, 0, 0, 0, 1);
    chk("reset_ready", instr_ready, 1);
    chk("reset_exv", ex_valid, 0);

    // Basic ADD with operands loaded via writeback
    step(0, 0, 16'h0, 1, 3'd1, 16'h0003, 1);
    step(0, 0, 16'h0, 1, 3'd2, 16'h0005, 1);
    step(0, 1, mk(3'd0, 3'd2, 3'd1), 0, 0, 0, 1);
    chk("add_op", ex_operation, 3'b000);
    chk("add_src", ex_src, 16'h0003);
    chk("add_dst", ex_dst, 16'h0005);
    chk("add_da", ex_dst_addr, 3'd2);

    // NOT on busy R2 stalls until writeback, then bypasses
    step(0, 1, mk(3'd1, 3'd2, 3'd0), 0, 0, 0, 1);
    chk("not_stalled", last_rdy, 0);
    step(0, 1, mk(3'd1, 3'd2, 3'd0), 0, 0, 0, 1);
    chk("stall_cnt2", stall_count, 16'd2);
    step(0, 1, mk(3'd1, 3'd2, 3'd0), 1, 3'd2, 16'h0008, 1);
    chk("not_bypass", ex_dst, 16'h0008);

    // Back-pressure holds the bundle
    step(0, 1, mk(3'd2, 3'd0, 3'd0), 0, 0, 0, 0);
    step(0, 1, mk(3'd2, 3'd0, 3'd0), 0, 0, 0, 0);
    chk("hold_dst", ex_dst, 16'h0008);
    step(0, 1, mk(3'd2, 3'd0, 3'd0), 0, 0, 0, 1);
    chk("release_op", ex_operation, 3'b010);

    // Illegal opcode issues as NOP and reserves nothing
    step(0, 1, mk(3'd7, 3'd5, 3'd5), 0, 0, 0, 1);
    chk("illegal_flag", ex_illegal, 1);
    chk("illegal_op", ex_operation, 3'b010);
    step(0, 1, mk(3'd1, 3'd5, 3'd0), 0, 0, 0, 1);
    chk("no_busy_r5", last_rdy, 1);

    // Same-cycle set and clear on R3: set wins
    step(0, 1, mk(3'd0, 3'd3, 3'd1), 1, 3'd3, 16'h1234, 1);
    chk("setwins_dst", ex_dst, 16'h1234);
    step(0, 1, mk(3'd1, 3'd3, 3'd0), 0, 0, 0, 1);
    chk("r3_still_busy", last_rdy, 0);

    // Reset mid-operation
    step(0, 1, mk(3'd0, 3'd4, 3'd4), 1, 3'd3, 16'h0001, 0);
    step(1, 1, mk(3'd1, 3'd4, 3'd0), 0, 0, 0, 0);
    chk("rst_exv", ex_valid, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_ready", instr_ready, 1);
    step(0, 1, mk(3'd0, 3'd2, 3'd1), 0, 0, 0, 1);
    chk("rst_rf_src", ex_src, 16'h0);
    chk("rst_rf_dst", ex_dst, 16'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, we, er;
      logic [15:0] ins, wd;
      logic [2:0]  wa;
      r   = ($urandom_range(0, 99) < 1);
      v   = ($urandom_range(0, 99) < 75);
      ins = 16'($urandom);
      we  = ($urandom_range(0, 99) < 45);
      wa  = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      er  = ($urandom_range(0, 99) < 70);
      step(r, v, ins, we, wa, wd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
